// File: rtl/spi_slave_bmm150_if.sv
// SPI pins plus the host-side sample/write-report port of the BMM150 emulator.
interface spi_slave_bmm150_if;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [63:0] sens_data;
    logic        sens_valid;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done;
    logic        busy;

    modport slave (
        input  sclk, cs_n, mosi, sens_data, sens_valid,
        output miso, wr_strobe, wr_addr, wr_data, frame_done, busy
    );

    modport master (
        output sclk, cs_n, mosi, sens_data, sens_valid,
        input  miso, wr_strobe, wr_addr, wr_data, frame_done, busy
    );
endinterface

// File: rtl/spi_slave_bmm150.sv
// SPI mode-0 responder emulating the BMM150 register map. SPI pins are
// oversampled in the clk domain; sensor samples arrive from the host port and
// are held back while a frame is running so a burst read sees one sample.
module spi_slave_bmm150 #(
    parameter logic [7:0] CHIP_ID      = 8'h32,
    parameter logic [6:0] CHIP_ID_ADDR = 7'h40,
    parameter logic [6:0] DATA_BASE    = 7'h42,
    parameter logic [6:0] CTRL_BASE    = 7'h4B
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_slave_bmm150_if.slave  bus
);

    typedef enum logic [2:0] {ARM, IDLE, ADDR, WR_DATA, RD_DATA} state_t;

    typedef struct packed {
        logic       strobe;
        logic [6:0] addr;
        logic [7:0] data;
    } wr_rpt_t;

    // synchronizers and edge detection
    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_prev, cs_prev;
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

    // frame state
    state_t     state;
    logic [2:0] cnt;
    logic [6:0] shift;
    logic [6:0] addr;
    logic [7:0] tx;
    logic       miso_q;
    logic       frame_done_q;
    wr_rpt_t    wr_q;

    // register storage
    logic [7:0][7:0] ctrl;
    logic [7:0][7:0] shadow;
    logic [63:0]     pending;
    logic            pend_vld;

    logic       busy_w;
    logic [6:0] addr_nxt;
    logic [6:0] wr_off;
    logic [7:0] rx_byte;

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise =  sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s &  sclk_prev;
    assign cs_rise   =  cs_s   & ~cs_prev;
    assign cs_fall   = ~cs_s   &  cs_prev;

    assign busy_w   = (state == ADDR) || (state == WR_DATA) || (state == RD_DATA);
    assign addr_nxt = addr + 7'd1;
    assign wr_off   = addr - CTRL_BASE;
    assign rx_byte  = {shift, mosi_s};

    assign bus.miso       = miso_q;
    assign bus.wr_strobe  = wr_q.strobe;
    assign bus.wr_addr    = wr_q.addr;
    assign bus.wr_data    = wr_q.data;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_w;

    // Read-side decode; offsets use 7-bit wrap so one compare covers each window.
    function automatic logic [7:0] read_val(input logic [6:0] a);
        logic [6:0] doff;
        logic [6:0] coff;
        doff     = a - DATA_BASE;
        coff     = a - CTRL_BASE;
        read_val = 8'h00;
        if (a == CHIP_ID_ADDR)
            read_val = CHIP_ID;
        else if (doff < 7'd8)
            read_val = shadow[doff[2:0]];
        else if (coff < 7'd8)
            read_val = ctrl[coff[2:0]];
    endfunction

    // Two-flop synchronizers; cs resets low so ARM waits for a real deassertion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.sclk};
            cs_sync   <= {cs_sync[0],   bus.cs_n};
            mosi_sync <= {mosi_sync[0], bus.mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    // Frame FSM: address decode, write commit, read shifter, frame termination.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ARM;
            cnt          <= '0;
            shift        <= '0;
            addr         <= '0;
            tx           <= '0;
            miso_q       <= 1'b0;
            frame_done_q <= 1'b0;
            wr_q         <= '0;
            ctrl         <= 64'h0000_0000_0000_0600;
        end else begin
            wr_q.strobe  <= 1'b0;
            frame_done_q <= 1'b0;
            if (state != ARM && cs_rise) begin
                // partial bytes are simply dropped
                state        <= IDLE;
                miso_q       <= 1'b0;
                frame_done_q <= 1'b1;
                cnt          <= '0;
            end else begin
                case (state)
                    ARM: begin
                        if (cs_s)
                            state <= IDLE;
                    end
                    IDLE: begin
                        miso_q <= 1'b0;
                        if (cs_fall) begin
                            cnt   <= '0;
                            shift <= '0;
                            state <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            shift <= {shift[5:0], mosi_s};
                            cnt   <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                addr <= rx_byte[6:0];
                                if (rx_byte[7]) begin
                                    state <= RD_DATA;
                                    tx    <= read_val(rx_byte[6:0]);
                                end else begin
                                    state <= WR_DATA;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sclk_rise) begin
                            shift <= {shift[5:0], mosi_s};
                            cnt   <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                if (wr_off < 7'd8) begin
                                    ctrl[wr_off[2:0]] <= rx_byte;
                                    wr_q <= '{strobe: 1'b1, addr: addr, data: rx_byte};
                                end
                                addr <= addr_nxt;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (sclk_fall) begin
                            miso_q <= tx[7];
                            tx     <= {tx[6:0], 1'b0};
                        end else if (sclk_rise) begin
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                addr <= addr_nxt;
                                tx   <= read_val(addr_nxt);
                            end
                        end
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

    // Sample shadow: direct load when idle, deferred to frame end while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow   <= '0;
            pending  <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (frame_done_q && pend_vld) begin
                shadow   <= pending;
                pend_vld <= 1'b0;
            end
            if (bus.sens_valid) begin
                if (busy_w) begin
                    pending  <= bus.sens_data;
                    pend_vld <= 1'b1;
                end else begin
                    shadow <= bus.sens_data;
                end
            end
        end
    end

endmodule
